// File: rtl/vec_load_unit_if.sv
// ----------------------------------------------------------------------------
// vec_load_unit_if
//
// Purpose:
//   Bundles every handshake and data bus that the vector load unit exposes:
//   the command queue port, the memory request/response ports, the vector
//   register-file write port and the completion pulse.
//
// Modports:
//   master - the environment around the unit (command queue, memory,
//            register file, sequencer)
//   slave  - the vector load unit itself
//
// Signals:
//   recv_msg/recv_val/recv_rdy        command {vd, vl, base} from the queue
//   memreq_addr/memreq_val/memreq_rdy element read requests to memory
//   memresp_data/memresp_val/memresp_rdy in-order read responses
//   rf_wen/rf_waddr/rf_widx/rf_wdata  element writes into the register file
//   done                              one-cycle completion pulse
// ----------------------------------------------------------------------------
interface vec_load_unit_if #(
    parameter int ADDR_W   = 32,
    parameter int DATA_W   = 32,
    parameter int VLEN_MAX = 8,
    parameter int VL_W     = $clog2(VLEN_MAX + 1),
    parameter int CMD_W    = 5 + VL_W + ADDR_W,
    parameter int IDX_W    = $clog2(VLEN_MAX)
);
    logic [CMD_W-1:0]  recv_msg;
    logic              recv_val;
    logic              recv_rdy;

    logic [ADDR_W-1:0] memreq_addr;
    logic              memreq_val;
    logic              memreq_rdy;

    logic [DATA_W-1:0] memresp_data;
    logic              memresp_val;
    logic              memresp_rdy;

    logic              rf_wen;
    logic [4:0]        rf_waddr;
    logic [IDX_W-1:0]  rf_widx;
    logic [DATA_W-1:0] rf_wdata;

    logic              done;

    modport master (
        output recv_msg, recv_val,
        input  recv_rdy,
        input  memreq_addr, memreq_val,
        output memreq_rdy,
        output memresp_data, memresp_val,
        input  memresp_rdy,
        input  rf_wen, rf_waddr, rf_widx, rf_wdata,
        input  done
    );

    modport slave (
        input  recv_msg, recv_val,
        output recv_rdy,
        output memreq_addr, memreq_val,
        input  memreq_rdy,
        input  memresp_data, memresp_val,
        output memresp_rdy,
        output rf_wen, rf_waddr, rf_widx, rf_wdata,
        output done
    );
endinterface

// File: rtl/vec_load_unit.sv
// ----------------------------------------------------------------------------
// vec_load_unit
//
// Purpose:
//   Pops one unit-stride vector load command at a time from the command
//   queue, issues one word read per element to memory and writes each
//   returned word straight into the vector register file. A one-cycle done
//   pulse follows the final element write (or the acceptance of an empty
//   command).
//
// Ports:
//   clk    - clock, all state updates on the rising edge
//   reset  - asynchronous, active-high reset
//   bus    - vec_load_unit_if.slave: command, memory request/response,
//            register-file write and done signals
// ----------------------------------------------------------------------------
module vec_load_unit #(
    parameter int ADDR_W   = 32,
    parameter int VLEN_MAX = 8
) (
    input  logic            clk,
    input  logic            reset,
    vec_load_unit_if.slave  bus
);
    localparam int VL_W  = $clog2(VLEN_MAX + 1);
    localparam int IDX_W = $clog2(VLEN_MAX);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_q;
    logic [4:0]        vd_q;
    logic [VL_W-1:0]   vl_eff_q;
    logic [ADDR_W-1:0] base_q;
    logic [VL_W-1:0]   req_cnt_q;
    logic [VL_W-1:0]   resp_cnt_q;
    logic              done_q;

    logic [4:0]        cmd_vd;
    logic [VL_W-1:0]   cmd_vl;
    logic [ADDR_W-1:0] cmd_base;
    logic [VL_W-1:0]   cmd_vl_eff;
    logic              recv_fire;
    logic              req_fire;
    logic              resp_fire;
    logic              last_resp;

    // Command fields; an oversized vl is clamped to the register length.
    assign cmd_vd     = bus.recv_msg[ADDR_W+VL_W +: 5];
    assign cmd_vl     = bus.recv_msg[ADDR_W +: VL_W];
    assign cmd_base   = bus.recv_msg[ADDR_W-1:0];
    assign cmd_vl_eff = (cmd_vl > VL_W'(VLEN_MAX)) ? VL_W'(VLEN_MAX) : cmd_vl;

    assign recv_fire  = bus.recv_val && bus.recv_rdy;
    assign req_fire   = bus.memreq_val && bus.memreq_rdy;
    assign resp_fire  = bus.memresp_val && bus.memresp_rdy;
    assign last_resp  = (resp_cnt_q == vl_eff_q - VL_W'(1));

    // Handshake outputs derive straight from the state register. Requests
    // are held until accepted because req_cnt only moves on a request fire,
    // and the address wraps naturally at 2^ADDR_W.
    assign bus.recv_rdy    = (state_q == IDLE);
    assign bus.memresp_rdy = (state_q == BUSY);
    assign bus.memreq_val  = (state_q == BUSY) && (req_cnt_q < vl_eff_q);
    assign bus.memreq_addr = base_q + (ADDR_W'(req_cnt_q) << 2);

    // Register-file writes happen in the very cycle a response fires, so the
    // write port is a pure function of the response handshake.
    assign bus.rf_wen   = resp_fire;
    assign bus.rf_waddr = vd_q;
    assign bus.rf_widx  = resp_cnt_q[IDX_W-1:0];
    assign bus.rf_wdata = bus.memresp_data;
    assign bus.done     = done_q;

    // Control FSM. IDLE latches a command; an empty command completes on the
    // spot. BUSY counts request and response fires independently (both may
    // fire in one cycle) and returns to IDLE on the last response, which lets
    // a new command be taken during the done cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= IDLE;
            vd_q       <= '0;
            vl_eff_q   <= '0;
            base_q     <= '0;
            req_cnt_q  <= '0;
            resp_cnt_q <= '0;
            done_q     <= 1'b0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (recv_fire) begin
                        vd_q     <= cmd_vd;
                        vl_eff_q <= cmd_vl_eff;
                        base_q   <= cmd_base;
                        if (cmd_vl_eff == '0) begin
                            done_q <= 1'b1;
                        end else begin
                            state_q    <= BUSY;
                            req_cnt_q  <= '0;
                            resp_cnt_q <= '0;
                        end
                    end
                end
                BUSY: begin
                    if (req_fire) begin
                        req_cnt_q <= req_cnt_q + VL_W'(1);
                    end
                    if (resp_fire) begin
                        resp_cnt_q <= resp_cnt_q + VL_W'(1);
                        if (last_resp) begin
                            state_q <= IDLE;
                            done_q  <= 1'b1;
                        end
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
endmodule

// File: doc/vec_load_unit.md
# vec_load_unit

Downstream consumer of the vector command queue: pops one unit-stride load command per operation, issues the element reads to memory over a val/rdy request port, and writes each returned word into the vector register file. It runs one command at a time. Back-pressure to the queue comes from `recv_rdy`, and a one-cycle `done` pulse reports completion to the sequencer.

## Interface
- ADDR_W, 32, memory address width
- DATA_W, 32, element / memory data width
- VLEN_MAX, 8, maximum elements per command; `vl` above this is clamped
- VL_W, $clog2(VLEN_MAX+1), width of the `vl` field
- CMD_W, 5+VL_W+ADDR_W, command width packed {vd[4:0], vl[VL_W-1:0], base[ADDR_W-1:0]}

Ports:
- clk  in  1  clock, all state on rising edge
- reset  in  1  asynchronous, active-high reset
- recv_msg  in  CMD_W  command from queue
- recv_val  in  1  command valid
- recv_rdy  out  1  ready to accept command
- memreq_addr  out  ADDR_W  byte address of element read
- memreq_val  out  1  request valid
- memreq_rdy  in  1  memory accepts request
- memresp_data  in  DATA_W  read data, in request order
- memresp_val  in  1  response valid
- memresp_rdy  out  1  ready for response
- rf_wen  out  1  register-file element write enable
- rf_waddr  out  5  destination vector register (latched `vd`)
- rf_widx  out  $clog2(VLEN_MAX)  element index
- rf_wdata  out  DATA_W  element data
- done  out  1  one-cycle pulse: command complete

## Operation
- States: IDLE, BUSY. Registers: vd, vl_eff, base, req_cnt, resp_cnt, done_q.
- IDLE: recv_rdy=1, memreq_val=0, memresp_rdy=0. On recv_val&&recv_rdy, latch fields and set vl_eff = min(vl, VLEN_MAX).
  - vl_eff==0: stay IDLE; done=1 next cycle.
  - Otherwise: go to BUSY and clear req_cnt and resp_cnt.
- BUSY: recv_rdy=0 and memresp_rdy=1.
  - memreq_val = (req_cnt < vl_eff).
  - memreq_addr = base + (req_cnt << 2), computed modulo 2^ADDR_W; wrap-around is permitted.
- Request fire (memreq_val&&memreq_rdy): req_cnt+1. Multiple outstanding requests are allowed, with no limit beyond vl_eff.
- Response fire (memresp_val&&memresp_rdy): in the same cycle, combinationally drive rf_wen=1, rf_waddr=vd, rf_widx=resp_cnt[...], rf_wdata=memresp_data. Then resp_cnt+1.
- When the response with resp_cnt==vl_eff-1 fires: go to IDLE at that edge and set done=1 for the following cycle. The unit may accept a new command in that same done cycle.
- A response in IDLE is not accepted (memresp_rdy=0) and produces no write.
- A request fire and a response fire in the same cycle both take effect.
- Reset (any time, including mid-BUSY): state=IDLE, all counters 0, done=0. Outstanding responses from before reset are the memory's responsibility; the unit does not track them.

## Timing
- Reset values of outputs: recv_rdy=1, memreq_val=0, memreq_addr=0 (base reg cleared), memresp_rdy=0, rf_wen=0, rf_waddr=0, rf_widx=0, rf_wdata=memresp_data passthrough (don't-care while rf_wen=0), done=0.
- Command accepted at edge N → memreq_val=1 with element 0 address in cycle N+1.
- With memreq_rdy held at 1, one request issues per cycle, so requests occupy cycles N+1..N+vl_eff.
- rf write has zero latency from response fire.
- done is high in the cycle after the last response fire, for exactly one cycle.
- memreq_addr and memreq_val hold stable while memreq_val=1 and memreq_rdy=0.
- rf_wen is never asserted without memresp_val.

## Test plan
- Basic load: cmd {vd=3, vl=4, base=0x100}, memreq_rdy=1, 1-cycle memory with data 0xA0..0xA3.
  - Requests go to 0x100, 0x104, 0x108, 0x10C in consecutive cycles.
  - rf writes are (3, 0..3, 0xA0..0xA3).
  - done pulses once, 1 cycle after the last write.
- Back-pressure: memreq_rdy toggles 0/1 every cycle and memresp_val is delayed 3 cycles; vl=3.
  - Address holds while stalled.
  - Exactly 3 requests and 3 writes occur, in order.
  - recv_rdy stays 0 until done.
- Boundaries, each sent as its own command:
  - vl=0: accepted with no requests; done in the next cycle.
  - vl=15 with VLEN_MAX=8: exactly 8 requests.
  - base=0xFFFFFFFC, vl=2: addresses 0xFFFFFFFC then 0x00000000.
- Back-to-back: queue holds 2 commands (vd=1, vl=2) and (vd=2, vl=1).
  - The second command is accepted in the done cycle of the first.
  - Its first request appears 1 cycle later; rf_waddr switches to 2.
- Reset mid-operation: assert reset after 2 of vl=4 requests.
  - Outputs return to reset values immediately.
  - A stray memresp_val in IDLE produces no rf_wen.
  - A following command vl=1 completes normally.
